alu_mdu_ctrl: RTL

//  EX-stage ALU control plus iterative multiply/divide unit (MDU) with HI/LO registers for the multicycle core.

---
 rtl/alu_pkg.sv | 73 +++++++
 rtl/alu_mdu_ctrl_mdu_iter.sv | 142 ++++++++++++++
 rtl/alu_mdu_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALUOp, ALU control, funct and MDU state/op definitions for alu_mdu_ctrl.
// Dividing support in the MDU is enabled with ALU_MDU_DIV_EN.
package alu_pkg;

  localparam logic [3:0] ALUOP_ADD  = 4'b0000;
  localparam logic [3:0] ALUOP_SUB  = 4'b0001;
  localparam logic [3:0] ALUOP_ADDU = 4'b0010;
  localparam logic [3:0] ALUOP_AND  = 4'b0011;
  localparam logic [3:0] ALUOP_LUI  = 4'b0100;
  localparam logic [3:0] ALUOP_OR   = 4'b0101;
  localparam logic [3:0] ALUOP_SLT  = 4'b0110;
  localparam logic [3:0] ALUOP_SLTU = 4'b0111;
  localparam logic [3:0] ALUOP_XOR  = 4'b1000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_SUBU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1011;
  localparam logic [3:0] ALU_SRA  = 4'b1100;
  localparam logic [3:0] ALU_LUI  = 4'b1101;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2
  } mdu_state_t;

  // Encoding equals funct[1:0] of mult/multu/div/divu.
  typedef enum logic [1:0] {
    MDU_OP_MULT  = 2'd0,
    MDU_OP_MULTU = 2'd1,
    MDU_OP_DIV   = 2'd2,
    MDU_OP_DIVU  = 2'd3
  } mdu_op_t;

  function automatic logic is_hilo_move(input logic [5:0] fn);
    return fn[5:2] == 4'b0100;
  endfunction

endpackage

// File: rtl/alu_mdu_ctrl_mdu_iter.sv
// Iterative multiply/divide datapath with HI/LO: one bit per cycle, DATA_W iterations.
// The restoring divider and DIV state exist only when ALU_MDU_DIV_EN is defined.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  mdu_op_t           i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  input  logic              i_we_hi,
  input  logic              i_we_lo,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  mdu_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_p;
  logic [DATA_W-1:0]   r_opb;
  logic                r_neg_q;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic                w_signed;
  logic                w_rs_neg;
  logic                w_rt_neg;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  logic [2*DATA_W-1:0] w_step;
  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_fin_hi;
  logic [DATA_W-1:0]   w_fin_lo;
  logic                w_last;

  assign w_signed = (i_op == MDU_OP_MULT) || (i_op == MDU_OP_DIV);
  assign w_rs_neg = w_signed & i_rs[DATA_W-1];
  assign w_rt_neg = w_signed & i_rt[DATA_W-1];
  assign w_mag_a  = w_rs_neg ? -i_rs : i_rs;
  assign w_mag_b  = w_rt_neg ? -i_rt : i_rt;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // r_p = {partial product, remaining multiplier bits}; shifted right each step.
  assign w_mul_sum  = {1'b0, r_p[2*DATA_W-1:DATA_W]} + (r_p[0] ? {1'b0, r_opb} : '0);
  assign w_mul_next = {w_mul_sum, r_p[DATA_W-1:1]};
  assign w_prod_fix = r_neg_q ? -w_step : w_step;

`ifdef ALU_MDU_DIV_EN
  logic                r_neg_r;
  logic [DATA_W:0]     w_rem_sh;
  logic [DATA_W:0]     w_trial;
  logic [2*DATA_W-1:0] w_div_next;
  logic [DATA_W-1:0]   w_div_q;
  logic [DATA_W-1:0]   w_div_r;

  // r_p = {remainder, dividend bits shifting out / quotient bits shifting in}.
  assign w_rem_sh   = {r_p[2*DATA_W-1:DATA_W], r_p[DATA_W-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_opb};
  assign w_div_next = w_trial[DATA_W] ? {w_rem_sh[DATA_W-1:0], r_p[DATA_W-2:0], 1'b0}
                                      : {w_trial[DATA_W-1:0], r_p[DATA_W-2:0], 1'b1};
  assign w_step     = (r_state == MDU_DIV) ? w_div_next : w_mul_next;
  assign w_div_q    = w_step[DATA_W-1:0];
  assign w_div_r    = w_step[2*DATA_W-1:DATA_W];

  always_comb begin
    w_fin_hi = w_prod_fix[2*DATA_W-1:DATA_W];
    w_fin_lo = w_prod_fix[DATA_W-1:0];
    if (r_state == MDU_DIV) begin
      w_fin_lo = r_neg_q ? -w_div_q : w_div_q;
      w_fin_hi = r_neg_r ? -w_div_r : w_div_r;
    end
  end
`else
  assign w_step   = w_mul_next;
  assign w_fin_hi = w_prod_fix[2*DATA_W-1:DATA_W];
  assign w_fin_lo = w_prod_fix[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
      r_p     <= '0;
      r_opb   <= '0;
      r_neg_q <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef ALU_MDU_DIV_EN
      r_neg_r <= 1'b0;
`endif
    end else begin
      if (i_we_hi) r_hi <= i_rs;
      if (i_we_lo) r_lo <= i_rs;
      if (r_state == MDU_IDLE) begin
        if (i_start) begin
          r_p     <= {{DATA_W{1'b0}}, w_mag_a};
          r_opb   <= w_mag_b;
          r_neg_q <= w_rs_neg ^ w_rt_neg;
          r_cnt   <= '0;
`ifdef ALU_MDU_DIV_EN
          r_neg_r <= w_rs_neg;
          if (i_op == MDU_OP_DIV || i_op == MDU_OP_DIVU) begin
            // Divide by zero finishes in the issue cycle without iterating.
            if (i_rt == '0) begin
              r_lo <= '1;
              r_hi <= i_rs;
            end else begin
              r_state <= MDU_DIV;
            end
          end else begin
            r_state <= MDU_MUL;
          end
`else
          r_state <= MDU_MUL;
`endif
        end
      end else begin
        r_p   <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_hi    <= w_fin_hi;
          r_lo    <= w_fin_lo;
          r_cnt   <= '0;
          r_state <= MDU_IDLE;
        end
      end
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != MDU_IDLE);

endmodule

// File: rtl/alu_mdu_ctrl.sv
// EX-stage ALU control decode, MDU issue/stall logic and HI/LO read mux.
// Define ALU_MDU_DIV_EN to execute div/divu; otherwise they are 1-cycle no-ops.
module alu_mdu_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [3:0]        alu_op,
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic [3:0]        alu_ctrl,
  output logic              alu_src_a,
  output logic              hilo_sel,
  output logic [DATA_W-1:0] hilo_rdata,
  output logic              stall,
  output logic              busy
);

  logic              w_rtype;
  logic              w_is_mfhi;
  logic              w_is_mflo;
  logic              w_is_mthi;
  logic              w_is_mtlo;
  logic              w_is_mul;
  logic              w_is_div;
  logic              w_mdu_fn;
  logic              w_start;
  logic              w_busy;
  logic [3:0]        w_ctrl;
  logic              w_src_a;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_lo;

  assign w_rtype   = (alu_op[3:2] == 2'b11);
  assign w_is_mfhi = w_rtype && (func == FN_MFHI);
  assign w_is_mflo = w_rtype && (func == FN_MFLO);
  assign w_is_mthi = w_rtype && (func == FN_MTHI);
  assign w_is_mtlo = w_rtype && (func == FN_MTLO);
  assign w_is_mul  = w_rtype && (func == FN_MULT || func == FN_MULTU);
`ifdef ALU_MDU_DIV_EN
  assign w_is_div  = w_rtype && (func == FN_DIV || func == FN_DIVU);
`else
  assign w_is_div  = 1'b0;
`endif
  assign w_mdu_fn  = (w_rtype && is_hilo_move(func)) || w_is_mul || w_is_div;

  always_comb begin
    w_ctrl  = ALU_ADD;
    w_src_a = 1'b0;
    if (w_rtype) begin
      case (func)
        FN_ADD:  w_ctrl = ALU_ADD;
        FN_ADDU: w_ctrl = ALU_ADDU;
        FN_SUB:  w_ctrl = ALU_SUB;
        FN_SUBU: w_ctrl = ALU_SUBU;
        FN_AND:  w_ctrl = ALU_AND;
        FN_OR:   w_ctrl = ALU_OR;
        FN_NOR:  w_ctrl = ALU_NOR;
        FN_XOR:  w_ctrl = ALU_XOR;
        FN_SLT:  w_ctrl = ALU_SLT;
        FN_SLTU: w_ctrl = ALU_SLTU;
        FN_SLL:  begin w_ctrl = ALU_SLL; w_src_a = 1'b1; end
        FN_SRL:  begin w_ctrl = ALU_SRL; w_src_a = 1'b1; end
        FN_SRA:  begin w_ctrl = ALU_SRA; w_src_a = 1'b1; end
        FN_SLLV: w_ctrl = ALU_SLL;
        FN_SRLV: w_ctrl = ALU_SRL;
        FN_SRAV: w_ctrl = ALU_SRA;
        default: w_ctrl = ALU_ADD;
      endcase
    end else begin
      case (alu_op)
        ALUOP_ADD:  w_ctrl = ALU_ADD;
        ALUOP_SUB:  w_ctrl = ALU_SUB;
        ALUOP_ADDU: w_ctrl = ALU_ADDU;
        ALUOP_AND:  w_ctrl = ALU_AND;
        ALUOP_LUI:  w_ctrl = ALU_LUI;
        ALUOP_OR:   w_ctrl = ALU_OR;
        ALUOP_SLT:  w_ctrl = ALU_SLT;
        ALUOP_SLTU: w_ctrl = ALU_SLTU;
        ALUOP_XOR:  w_ctrl = ALU_XOR;
        default:    w_ctrl = ALU_ADD;
      endcase
    end
  end

  assign alu_ctrl  = valid ? w_ctrl : '0;
  assign alu_src_a = valid & w_src_a;
  assign hilo_sel  = valid & (w_is_mfhi | w_is_mflo);
  assign stall     = valid & w_busy & w_mdu_fn;
  assign w_start   = valid & ~w_busy & (w_is_mul | w_is_div);

  mdu_iter #(
    .DATA_W(DATA_W)
  ) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_op    (mdu_op_t'(func[1:0])),
    .i_rs    (rs_val),
    .i_rt    (rt_val),
    .i_we_hi (valid & w_is_mthi & ~stall),
    .i_we_lo (valid & w_is_mtlo & ~stall),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_busy  (w_busy)
  );

  assign hilo_rdata = w_is_mfhi ? w_hi : w_lo;
  assign busy       = w_busy;

endmodule
